// File: rtl/relay_station_credit.sv
// Credit-style FWFT relay station: FWD_LEVEL-deep write pipeline, BWD_LEVEL-deep full_n
// return path, and a DEPTH-entry circular buffer at the consumer end with debug status.
module relay_station_credit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 8,
    parameter int FWD_LEVEL  = 2,
    parameter int BWD_LEVEL  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic [ADDR_WIDTH:0]   peak_occupancy,
    output logic                  overflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int INF_W = $clog2(FWD_LEVEL + 1);
    localparam int CMP_W = ADDR_WIDTH + INF_W + 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    if (DEPTH < BWD_LEVEL + 1 || DEPTH > (1 << ADDR_WIDTH) || FWD_LEVEL < 1 || BWD_LEVEL < 1) begin : g_paramCheck
        $error("relay_station_credit: illegal DEPTH/ADDR_WIDTH/FWD_LEVEL/BWD_LEVEL combination");
    end

    logic [FWD_LEVEL-1:0]  r_fwdValid;
    logic [DATA_WIDTH-1:0] r_fwdData [FWD_LEVEL];
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wrPtr;
    logic [ADDR_WIDTH-1:0] r_rdPtr;
    logic [ADDR_WIDTH:0]   r_occupancy;
    logic [ADDR_WIDTH:0]   r_peak;
    logic                  r_overflow;
    logic [BWD_LEVEL-1:0]  r_fullChain;

    logic                  w_lastValid;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [ADDR_WIDTH:0]   w_occNext;
    logic [INF_W-1:0]      w_inflight;
    logic [CMP_W-1:0]      w_used;
    logic                  w_fullNInt;
    logic [IDX_W-1:0]      w_wrIdx;
    logic [IDX_W-1:0]      w_rdIdx;

    function automatic logic [ADDR_WIDTH-1:0] nextPtr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fwdValid <= '0;
        end else begin
            r_fwdValid[0] <= if_write & if_write_ce;
            for (int k = 1; k < FWD_LEVEL; k++) begin
                r_fwdValid[k] <= r_fwdValid[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_fwdData[0] <= if_din;
        for (int k = 1; k < FWD_LEVEL; k++) begin
            r_fwdData[k] <= r_fwdData[k-1];
        end
    end

    assign w_lastValid = r_fwdValid[FWD_LEVEL-1];
    assign w_full      = (r_occupancy == FULL_COUNT);
    assign w_pop       = if_read & if_read_ce & (r_occupancy != '0);
    // A pop in the same cycle frees the slot the full buffer would otherwise refuse.
    assign w_push      = w_lastValid & (~w_full | w_pop);
    assign w_drop      = w_lastValid & w_full & ~w_pop;
    assign w_wrIdx     = IDX_W'(r_wrPtr);
    assign w_rdIdx     = IDX_W'(r_rdPtr);

    always_comb begin
        w_occNext = r_occupancy;
        if (w_push && !w_pop) begin
            w_occNext = r_occupancy + 1'b1;
        end else if (w_pop && !w_push) begin
            w_occNext = r_occupancy - 1'b1;
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < FWD_LEVEL; k++) begin
            w_inflight = w_inflight + INF_W'(r_fwdValid[k]);
        end
    end

    // Equivalent to DEPTH - occupancy - inflight > BWD_LEVEL, kept unsigned.
    assign w_used     = CMP_W'(r_occupancy) + CMP_W'(w_inflight);
    assign w_fullNInt = (w_used + CMP_W'(BWD_LEVEL)) < CMP_W'(DEPTH);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wrIdx] <= r_fwdData[FWD_LEVEL-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_occupancy <= '0;
            r_peak      <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            r_occupancy <= w_occNext;
            r_peak      <= (w_occNext > r_peak) ? w_occNext : r_peak;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fullChain <= '0;
        end else begin
            r_fullChain[0] <= w_fullNInt;
            for (int k = 1; k < BWD_LEVEL; k++) begin
                r_fullChain[k] <= r_fullChain[k-1];
            end
        end
    end

    assign if_full_n      = r_fullChain[BWD_LEVEL-1];
    assign if_empty_n     = (r_occupancy != '0);
    assign if_dout        = r_mem[w_rdIdx];
    assign occupancy      = r_occupancy;
    assign peak_occupancy = r_peak;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_relay_station_credit.sv
// Bench for relay_station_credit: two configurations (8/2/2 and 6/1/1) checked every cycle
// against a queue-based model, plus directed latency, backpressure, overflow and reset cases.
module tb_relay_station_credit;

    logic        clk;
    logic        reset_n;

    logic        aWrite, aWriteCe, aRead, aReadCe;
    logic [31:0] aDin;
    logic        aFullN, aEmptyN, aOverflow;
    logic [31:0] aDout;
    logic [5:0]  aOcc, aPeak;

    logic        bWrite, bWriteCe, bRead, bReadCe;
    logic [31:0] bDin;
    logic        bFullN, bEmptyN, bOverflow;
    logic [31:0] bDout;
    logic [3:0]  bOcc, bPeak;

    int total;
    int bad;

    relay_station_credit #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(8), .FWD_LEVEL(2), .BWD_LEVEL(2)
    ) dutA (
        .clk(clk), .reset_n(reset_n), .if_full_n(aFullN), .if_write_ce(aWriteCe),
        .if_write(aWrite), .if_din(aDin), .if_empty_n(aEmptyN), .if_read_ce(aReadCe),
        .if_read(aRead), .if_dout(aDout), .occupancy(aOcc), .peak_occupancy(aPeak),
        .overflow(aOverflow)
    );

    relay_station_credit #(
        .DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(6), .FWD_LEVEL(1), .BWD_LEVEL(1)
    ) dutB (
        .clk(clk), .reset_n(reset_n), .if_full_n(bFullN), .if_write_ce(bWriteCe),
        .if_write(bWrite), .if_din(bDin), .if_empty_n(bEmptyN), .if_read_ce(bReadCe),
        .if_read(bRead), .if_dout(bDout), .occupancy(bOcc), .peak_occupancy(bPeak),
        .overflow(bOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: buffer contents as queues, the forward path and the full_n return
    // path as plain delay lines, everything else derived from counts.
    logic [31:0] qA[$];
    logic [31:0] qB[$];
    logic        mPipeV [2][4];
    logic [31:0] mPipeD [2][4];
    logic        mFullHist [2][4];
    int          mPeak [2];
    logic        mOvf [2];

    function automatic int depthOf(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic int fwdOf(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int bwdOf(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int bufSize(input int d);
        return (d == 0) ? qA.size() : qB.size();
    endfunction

    task automatic bufPush(input int d, input logic [31:0] x);
        if (d == 0) qA.push_back(x);
        else qB.push_back(x);
    endtask

    task automatic bufPop(input int d);
        if (d == 0) void'(qA.pop_front());
        else void'(qB.pop_front());
    endtask

    task automatic modelReset();
        qA.delete();
        qB.delete();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                mPipeV[d][k]    = 1'b0;
                mPipeD[d][k]    = '0;
                mFullHist[d][k] = 1'b0;
            end
            mPeak[d] = 0;
            mOvf[d]  = 1'b0;
        end
    endtask

    task automatic modelStep(input int d);
        int          f, b, dep, infl, sz;
        logic        fullInt, pop, wr, outV;
        logic [31:0] din, outD;
        f   = fwdOf(d);
        b   = bwdOf(d);
        dep = depthOf(d);
        infl = 0;
        for (int k = 0; k < f; k++) infl += int'(mPipeV[d][k]);
        sz      = bufSize(d);
        fullInt = (dep - sz - infl) > b;
        outV    = mPipeV[d][f-1];
        outD    = mPipeD[d][f-1];
        pop     = ((d == 0) ? (aRead & aReadCe) : (bRead & bReadCe)) && (sz > 0);
        wr      = (d == 0) ? (aWrite & aWriteCe) : (bWrite & bWriteCe);
        din     = (d == 0) ? aDin : bDin;
        if (pop) bufPop(d);
        if (outV) begin
            if (bufSize(d) < dep) bufPush(d, outD);
            else mOvf[d] = 1'b1;
        end
        for (int k = f - 1; k > 0; k--) begin
            mPipeV[d][k] = mPipeV[d][k-1];
            mPipeD[d][k] = mPipeD[d][k-1];
        end
        mPipeV[d][0] = wr;
        mPipeD[d][0] = din;
        for (int k = b - 1; k > 0; k--) mFullHist[d][k] = mFullHist[d][k-1];
        mFullHist[d][0] = fullInt;
        if (bufSize(d) > mPeak[d]) mPeak[d] = bufSize(d);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic compareDut(input int d);
        if (d == 0) begin
            checkOutput("A.emptyN", 32'(aEmptyN), 32'(qA.size() != 0));
            if (qA.size() != 0) checkOutput("A.dout", aDout, qA[0]);
            checkOutput("A.occ", 32'(aOcc), 32'(qA.size()));
            checkOutput("A.peak", 32'(aPeak), 32'(mPeak[0]));
            checkOutput("A.overflow", 32'(aOverflow), 32'(mOvf[0]));
            checkOutput("A.fullN", 32'(aFullN), 32'(mFullHist[0][1]));
        end else begin
            checkOutput("B.emptyN", 32'(bEmptyN), 32'(qB.size() != 0));
            if (qB.size() != 0) checkOutput("B.dout", bDout, qB[0]);
            checkOutput("B.occ", 32'(bOcc), 32'(qB.size()));
            checkOutput("B.peak", 32'(bPeak), 32'(mPeak[1]));
            checkOutput("B.overflow", 32'(bOverflow), 32'(mOvf[1]));
            checkOutput("B.fullN", 32'(bFullN), 32'(mFullHist[1][0]));
        end
    endtask

    task automatic applyStimulus(input int d, input logic wr, input logic wce,
                                 input logic [31:0] data, input logic rd, input logic rce);
        if (d == 0) begin
            aWrite = wr; aWriteCe = wce; aDin = data; aRead = rd; aReadCe = rce;
        end else begin
            bWrite = wr; bWriteCe = wce; bDin = data; bRead = rd; bReadCe = rce;
        end
    endtask

    // One clock: model advances on the rising edge, both DUTs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (reset_n) begin
            modelStep(0);
            modelStep(1);
        end
        @(negedge clk);
        compareDut(0);
        compareDut(1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   sent, got, cyc;
        logic w, rd, inOrder, fullDropped;
        total = 0;
        bad   = 0;
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        compareDut(0);
        compareDut(1);
        checkOutput("rst.A.fullN", 32'(aFullN), 0);
        checkOutput("rst.A.emptyN", 32'(aEmptyN), 0);
        repeat (2) cycle();

        $display("[TB] release reset");
        reset_n = 1'b1;
        cycle();
        checkOutput("rel.A.fullN.edge1", 32'(aFullN), 0);
        cycle();
        checkOutput("rel.A.fullN.edge2", 32'(aFullN), 1);
        checkOutput("rel.B.fullN", 32'(bFullN), 1);

        $display("[TB] latency");
        applyStimulus(0, 1, 1, 32'hA5, 0, 1);
        cycle();
        applyStimulus(0, 0, 1, 0, 0, 1);
        cycle();
        checkOutput("lat.t2.emptyN", 32'(aEmptyN), 0);
        cycle();
        checkOutput("lat.t3.emptyN", 32'(aEmptyN), 1);
        checkOutput("lat.t3.dout", aDout, 32'hA5);
        applyStimulus(0, 0, 1, 0, 1, 1);
        cycle();
        checkOutput("lat.pop.emptyN", 32'(aEmptyN), 0);
        checkOutput("lat.pop.occ", 32'(aOcc), 0);

        $display("[TB] streaming");
        sent = 0; got = 0; cyc = 0; inOrder = 1'b1; fullDropped = 1'b0;
        while (got < 100 && cyc < 500) begin
            if (aEmptyN) begin
                if (aDout != 32'(got)) inOrder = 1'b0;
                got++;
            end
            if (!aFullN) fullDropped = 1'b1;
            w = (sent < 100) && aFullN;
            applyStimulus(0, w, 1, 32'(sent), 1, 1);
            if (w) sent++;
            cycle();
            cyc++;
        end
        checkOutput("stream.count", 32'(got), 100);
        checkOutput("stream.order", 32'(inOrder), 1);
        checkOutput("stream.fullNHeld", 32'(fullDropped), 0);
        checkOutput("stream.peakLe2", 32'(aPeak <= 6'd2), 1);
        checkOutput("stream.rate", 32'(cyc <= 105), 1);

        $display("[TB] backpressure");
        sent = 0;
        for (int i = 0; i < 40; i++) begin
            w = aFullN;
            applyStimulus(0, w, 1, 32'(sent), 0, 1);
            if (w) sent++;
            cycle();
        end
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("bp.accepted", 32'(sent), 8);
        checkOutput("bp.occ", 32'(aOcc), 8);
        checkOutput("bp.peak", 32'(aPeak), 8);
        checkOutput("bp.overflow", 32'(aOverflow), 0);
        got = 0; inOrder = 1'b1;
        for (int i = 0; i < 30 && got < 8; i++) begin
            if (aEmptyN) begin
                if (aDout != 32'(got)) inOrder = 1'b0;
                got++;
            end
            applyStimulus(0, 0, 1, 0, 1, 1);
            cycle();
        end
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("bp.drainCount", 32'(got), 8);
        checkOutput("bp.drainOrder", 32'(inOrder), 1);

        $display("[TB] random A");
        for (int i = 0; i < 300; i++) begin
            w = aFullN ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            applyStimulus(0, w, aFullN ? ($urandom_range(0, 4) != 0) : 1'b0, $urandom,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0);
            cycle();
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 1, 0, 1, 1);
            cycle();
        end
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("randA.overflow", 32'(aOverflow), 0);

        $display("[TB] wrap B");
        sent = 0; got = 0; cyc = 0; inOrder = 1'b1;
        while (got < 40 && cyc < 600) begin
            rd = ($urandom_range(0, 2) != 0);
            if (rd && bEmptyN) begin
                if (bDout != 32'h100 + 32'(got)) inOrder = 1'b0;
                got++;
            end
            w = (sent < 40) && bFullN;
            applyStimulus(1, w, 1, 32'h100 + 32'(sent), rd, 1);
            if (w) sent++;
            cycle();
            cyc++;
        end
        checkOutput("wrap.count", 32'(got), 40);
        checkOutput("wrap.order", 32'(inOrder), 1);

        sent = 0;
        for (int i = 0; i < 20; i++) begin
            w = bFullN;
            applyStimulus(1, w, 1, 32'h200 + 32'(sent), 0, 1);
            if (w) sent++;
            cycle();
        end
        checkOutput("fill.accepted", 32'(sent), 6);
        checkOutput("fill.occ", 32'(bOcc), 6);
        checkOutput("fill.fullN", 32'(bFullN), 0);
        applyStimulus(1, 1, 1, 32'hDEAD, 0, 1);
        cycle();
        applyStimulus(1, 0, 1, 0, 0, 1);
        cycle();
        cycle();
        checkOutput("ovf.flag", 32'(bOverflow), 1);
        checkOutput("ovf.occ", 32'(bOcc), 6);
        got = 0; inOrder = 1'b1;
        for (int i = 0; i < 20 && got < 6; i++) begin
            if (bEmptyN) begin
                if (bDout != 32'h200 + 32'(got)) inOrder = 1'b0;
                got++;
            end
            applyStimulus(1, 0, 1, 0, 1, 1);
            cycle();
        end
        applyStimulus(1, 0, 1, 0, 0, 1);
        checkOutput("ovf.contents", 32'(inOrder), 1);
        checkOutput("ovf.drained", 32'(got), 6);
        cycle();
        checkOutput("ovf.sticky", 32'(bOverflow), 1);

        $display("[TB] mid-operation reset");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 1, 32'h300 + 32'(i), 0, 1);
            cycle();
        end
        applyStimulus(0, 0, 1, 0, 0, 1);
        repeat (3) cycle();
        checkOutput("mid.occ5", 32'(aOcc), 5);
        applyStimulus(0, 1, 1, 32'h400, 0, 1);
        cycle();
        applyStimulus(0, 1, 1, 32'h401, 0, 1);
        cycle();
        applyStimulus(0, 0, 1, 0, 0, 1);
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("mid.fullN", 32'(aFullN), 0);
        checkOutput("mid.emptyN", 32'(aEmptyN), 0);
        checkOutput("mid.occ", 32'(aOcc), 0);
        checkOutput("mid.peak", 32'(aPeak), 0);
        checkOutput("mid.B.overflow", 32'(bOverflow), 0);
        compareDut(0);
        compareDut(1);
        repeat (2) cycle();
        reset_n = 1'b1;
        repeat (2) cycle();
        applyStimulus(0, 1, 1, 32'h500, 1, 1);
        cycle();
        applyStimulus(0, 1, 1, 32'h501, 1, 1);
        cycle();
        applyStimulus(0, 0, 1, 0, 1, 1);
        got = 0; inOrder = 1'b1;
        for (int i = 0; i < 20 && got < 2; i++) begin
            if (aEmptyN) begin
                if (aDout != 32'h500 + 32'(got)) inOrder = 1'b0;
                got++;
            end
            cycle();
        end
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("post.count", 32'(got), 2);
        checkOutput("post.order", 32'(inOrder), 1);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
